// File: rtl/lsu.sv
// Load/store unit: runs one data-bus transaction per start pulse.
// The effective address comes from the ALU result. Store data comes from rs2.
// Load data is returned to the write-back mux after sign or zero extension.
// Instructions that do not touch memory complete in one cycle, so the
// control unit can step every instruction through this stage the same way.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   mem_valid  start pulse, sampled only in IDLE
//   is_load    instruction is a load
//   is_store   instruction is a store
//   funct3     [1:0] access size B/H/W/D, [2] unsigned load
//   addr       effective address
//   wdata      store data (rs2)
//   dreq       data-bus request (valid, addr, size, strobe, data)
//   dresp      data-bus response (addr_ok, data_ok, data)
//   rdata      extended load data
//   mem_finish one-cycle completion pulse
//   misalign   qualifies mem_finish: access was misaligned and not issued

package common;
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | waiting for mem_valid; operands latched on the start pulse
// BUSY  | bus request held valid until data_ok
// DONE  | mem_finish pulse; misalign reported; back to IDLE
module lsu
   import common::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output dbus_req_t   dreq,
   input  dbus_resp_t  dresp,
   output logic [63:0] rdata,
   output logic        mem_finish,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_next;
   logic        ld_r, st_r, misalign_r;
   logic [2:0]  funct3_r;
   logic [63:0] addr_r, wdata_r, rdata_r;
   logic        mem_op, aligned_in;
   logic [63:0] ld_shift, ld_ext;
   logic [7:0]  size_mask;
   logic        unused_addr_ok;

   // Requests are held until data_ok, so addr_ok carries no information here.
   assign unused_addr_ok = dresp.addr_ok;

   assign mem_op = is_load | is_store;

   always_comb begin
      aligned_in = 1'b1;
      case (funct3[1:0])
         2'd0: aligned_in = 1'b1;
         2'd1: aligned_in = (addr[0] == 1'b0);
         2'd2: aligned_in = (addr[1:0] == 2'b00);
         2'd3: aligned_in = (addr[2:0] == 3'b000);
         default: aligned_in = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (mem_valid) state_next = (mem_op && aligned_in) ? BUSY : DONE;
         BUSY: if (dresp.data_ok) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane-align the returned doubleword, then extend to 64 bits.
   always_comb begin
      ld_shift = dresp.data >> {addr_r[2:0], 3'b000};
      ld_ext   = ld_shift;
      case (funct3_r[1:0])
         2'd0: ld_ext = funct3_r[2] ? {56'd0, ld_shift[7:0]}
                                    : {{56{ld_shift[7]}}, ld_shift[7:0]};
         2'd1: ld_ext = funct3_r[2] ? {48'd0, ld_shift[15:0]}
                                    : {{48{ld_shift[15]}}, ld_shift[15:0]};
         2'd2: ld_ext = funct3_r[2] ? {32'd0, ld_shift[31:0]}
                                    : {{32{ld_shift[31]}}, ld_shift[31:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_r       <= 1'b0;
         st_r       <= 1'b0;
         funct3_r   <= 3'd0;
         addr_r     <= 64'd0;
         wdata_r    <= 64'd0;
         rdata_r    <= 64'd0;
         misalign_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mem_valid) begin
               ld_r       <= is_load;
               st_r       <= is_store;
               funct3_r   <= funct3;
               addr_r     <= addr;
               wdata_r    <= wdata;
               rdata_r    <= 64'd0;
               misalign_r <= mem_op & ~aligned_in;
            end
            BUSY: if (dresp.data_ok && ld_r) rdata_r <= ld_ext;
            default: ;
         endcase
      end
   end

   always_comb begin
      size_mask = 8'h01;
      case (funct3_r[1:0])
         2'd0: size_mask = 8'h01;
         2'd1: size_mask = 8'h03;
         2'd2: size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Request fields come only from registered state, so nothing in dresp
   // reaches dreq within a cycle. A set is_load takes priority over is_store.
   always_comb begin
      dreq      = '0;
      dreq.addr = addr_r;
      dreq.size = msize_t'({1'b0, funct3_r[1:0]});
      if (state == BUSY) begin
         dreq.valid = 1'b1;
         if (st_r && !ld_r) begin
            dreq.data   = wdata_r << {addr_r[2:0], 3'b000};
            dreq.strobe = size_mask << addr_r[2:0];
         end
      end
   end

   assign rdata      = rdata_r;
   assign mem_finish = (state == DONE);
   assign misalign   = (state == DONE) & misalign_r;

endmodule
